// File: rtl/mem_pkg.sv
// Shared types for the wait-state data memory: FSM state encoding and counter sizing.
// No logic; latency and backpressure behaviour live in mem_data_wait.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Wide enough to hold the larger latency minus one, with a spare bit.
  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mem_data_array.sv
// Single-port word store: synchronous write, registered read (data valid the cycle after i_re).
// No backpressure; the caller issues at most one operation per cycle.
module mem_data_array #(
  parameter int p_SIZE  = 1024,
  parameter int p_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic                       i_re,
  input  logic [$clog2(p_SIZE)-1:0]  i_idx,
  input  logic [p_WIDTH-1:0]         i_wdata,
  output logic [p_WIDTH-1:0]         o_rdata
);

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [p_WIDTH-1:0] r_mem [p_SIZE] = '{default: '0};
  logic [p_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_data_wait.sv
// Data memory with programmable wait states: response pulse LAT+1 cycles after accept.
// One request in flight; req_ready drops from accept until the response cycle ends, no response stall.
module mem_data_wait #(
  parameter int                    p_DATA_MEM_SIZE = 1024,
  parameter int                    p_WORD_LEN      = 16,
  parameter int                    p_ADDR_LEN      = 16,
  parameter logic [p_ADDR_LEN-1:0] p_BASE_ADDR     = '0,
  parameter int                    p_READ_LAT      = 2,
  parameter int                    p_WRITE_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [p_ADDR_LEN-1:0] req_addr,
  input  logic [p_WORD_LEN-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [p_WORD_LEN-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);
  import mem_pkg::*;

  localparam int IDX_W = $clog2(p_DATA_MEM_SIZE);
  localparam int CNT_W = cnt_width(p_READ_LAT, p_WRITE_LAT);
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(p_READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(p_WRITE_LAT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic                  r_in_range;
  logic [IDX_W-1:0]      r_idx;
  logic [p_WORD_LEN-1:0] r_wdata;
  logic                  r_ready;
  logic                  r_resp_vld;
  logic                  r_err;
  logic                  r_rd_sel;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_we;
  logic                  w_re;
  logic [p_WORD_LEN-1:0] w_arr_rdata;

  assign w_accept   = req_valid && r_ready;
  assign w_in_range = (req_addr[p_ADDR_LEN-1:IDX_W] == p_BASE_ADDR[p_ADDR_LEN-1:IDX_W]);
  assign w_we       = (r_state == S_ACCESS) && r_write && r_in_range;
  assign w_re       = (r_state == S_ACCESS) && !r_write && r_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_in_range <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b1;
      r_resp_vld <= 1'b0;
      r_err      <= 1'b0;
      r_rd_sel   <= 1'b0;
    end else begin
      r_resp_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_in_range <= w_in_range;
            r_idx      <= req_addr[IDX_W-1:0];
            r_wdata    <= req_wdata;
            r_ready    <= 1'b0;
            if (req_write) begin
              r_cnt   <= WR_CNT;
              r_state <= (p_WRITE_LAT == 1) ? S_ACCESS : S_WAIT;
            end else begin
              r_cnt   <= RD_CNT;
              r_state <= (p_READ_LAT == 1) ? S_ACCESS : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // Read data comes straight from the array's output register, gated by r_rd_sel.
          r_err      <= !r_in_range;
          r_rd_sel   <= !r_write && r_in_range;
          r_resp_vld <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mem_data_array #(
    .p_SIZE  (p_DATA_MEM_SIZE),
    .p_WIDTH (p_WORD_LEN)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  assign req_ready  = r_ready;
  assign busy       = !r_ready;
  assign resp_valid = r_resp_vld;
  assign resp_err   = r_err;
  assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;

endmodule

// File: doc/mem_data_wait.md
Name: mem_data_wait

Overview:
- Parametrised successor to the single-cycle data memory, for the pipelined and multi-cycle RiSC-16 cores.
- Accepts one request at a time through a valid/ready handshake.
- Reads and writes complete after a configurable number of wait states.
- Each request gets a one-cycle response pulse carrying read data and an out-of-range error flag.
- Sits between the core's load/store unit and the word-addressed data store; the base address is relocatable.

Parameters:
p_DATA_MEM_SIZE, 1024, words stored; power of 2, at least 2
p_WORD_LEN, 16, data word width
p_ADDR_LEN, 16, address width; must exceed $clog2(p_DATA_MEM_SIZE)
p_BASE_ADDR, 0, first mapped word address; aligned to p_DATA_MEM_SIZE
p_READ_LAT, 2, cycles from read accept to response; at least 1
p_WRITE_LAT, 1, cycles from write accept to response; at least 1

Ports:
clk  in  1  clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  p_ADDR_LEN  word address
req_wdata  in  p_WORD_LEN  write data
resp_valid  out  1  single-cycle response pulse
resp_rdata  out  p_WORD_LEN  read data; 0 for writes and errors
resp_err  out  1  address was outside the mapped window
busy  out  1  request in flight (inverse of req_ready)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory contents are not cleared by reset. Memory is zero-initialised at time 0 only.
- States:
  - IDLE: req_ready=1.
    - Accept on the rising edge where req_valid && req_ready.
    - Latch addr, wdata and write; compute in_range; load cnt = LAT-1, where LAT is p_WRITE_LAT or p_READ_LAT by type.
    - If LAT==1, go to ACCESS; otherwise go to WAIT.
  - WAIT: req_ready=0. Decrement cnt each cycle; go to ACCESS on the cycle cnt reaches 1.
  - ACCESS: one cycle; the array operation happens at the end of this cycle.
    - Write with in_range: commit the word.
    - Read with in_range: register the array output into resp_rdata.
    - Out of range: no array access; resp_rdata=0, resp_err=1.
    - Next state is RESP.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 during RESP.
- Timing: if the accept edge ends cycle 0, resp_valid is high in cycle LAT+1.
  - Throughput is one request per LAT+2 cycles.
- Range check: in_range = (req_addr[p_ADDR_LEN-1:log2 SIZE] == p_BASE_ADDR[p_ADDR_LEN-1:log2 SIZE]). The index is req_addr[log2 SIZE - 1:0].
- Inputs are don't-care outside the accept edge. Request fields are sampled only at accept.
- There is no response backpressure: the consumer must take resp_valid when it pulses.
- resp_rdata and resp_err hold their value after RESP until the next ACCESS.
- Reset mid-operation: the request is dropped and no response is issued.
  - A write whose ACCESS edge has not occurred is not committed.
  - An ACCESS-edge write coincident with rst_n falling is undefined; tests avoid it.
- Read of a just-written address in a later request returns the new data; there is no stale window.

Decomposition:
- Package mem_pkg:
  - state enum (IDLE, WAIT, ACCESS, RESP) with 2-bit encoding;
  - helper function for the latency counter width, $clog2(max latency)+1.
- Sub-module mem_data_array: synchronous write, registered read, single port, parametrised by size and width. The FSM wraps it.

Test Plan:
- Defaults: write 0xBEEF to addr 5; read addr 5 -> resp_valid in cycle 2 after write accept with err=0; read response in cycle 3 after its accept with rdata=0xBEEF.
- Out-of-range read and write at addr 0x0400 (SIZE=1024, BASE=0) -> resp_err=1, rdata=0; a later read of addr 0 still returns its prior value (0).
- p_BASE_ADDR=0x8000, p_READ_LAT=4:
  - write 0x1234 to 0x8003, read it back -> rdata=0x1234 exactly 5 cycles after the read accept;
  - read 0x0003 -> resp_err=1.
- Back-to-back: req_valid held high for 3 writes -> req_ready low from accept until RESP ends; each accepted exactly once, spaced LAT+2 cycles.
- Reset mid-operation: write 0xAAAA to addr 7 (p_WRITE_LAT=3), assert rst_n low during WAIT -> no resp_valid; a subsequent read of 7 returns 0.
- Boundary: write and read addresses 0 and 1023 with values 0xFFFF and 0x0001 -> correct data, no aliasing.
